// File: rtl/mmio_peripherals.sv
// mmio_peripherals
//   Memory-mapped peripheral block that sits next to data memory on the CPU
//   data bus and answers the 0x4000_0000..0x4000_001F window. It contains:
//   - a reloading 32-bit timer with a sticky interrupt,
//   - an 8-bit LED register,
//   - a 4-digit multiplexed 7-segment scan driver,
//   - a free-running 32-bit system tick counter.
//
// Ports
//   clk, reset      clock, asynchronous active-high reset
//   addr            byte address from the ALU (addr[1:0] ignored)
//   wdata           store data
//   MemRead         load strobe; rdata is zero unless MemRead & hit
//   MemWrite        store strobe; the write lands on the next rising edge
//   hit             combinational window decode
//   rdata           combinational read data
//   irq             timer interrupt request (TCON[2])
//   leds            LED register
//   an              digit enables, active-low, one-hot-low
//   seg             segments, active-low, {dp, g..a}; dp is always off
module mmio_peripherals #(
    parameter int SCAN_DIV = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        MemRead,
    input  logic        MemWrite,
    output logic        hit,
    output logic [31:0] rdata,
    output logic        irq,
    output logic [7:0]  leds,
    output logic [3:0]  an,
    output logic [7:0]  seg
);

    // Word offsets within the window (addr[4:2])
    localparam logic [2:0] REG_TH      = 3'd0;
    localparam logic [2:0] REG_TL      = 3'd1;
    localparam logic [2:0] REG_TCON    = 3'd2;
    localparam logic [2:0] REG_LED     = 3'd3;
    localparam logic [2:0] REG_DIGITS  = 3'd4;
    localparam logic [2:0] REG_SYSTICK = 3'd5;

    // SCAN_DIV is at most 2^20, so its terminal count fits in 20 bits.
    localparam logic [19:0] PRESC_LAST = 20'(SCAN_DIV - 1);

    logic [31:0] th_q,      th_d;
    logic [31:0] tl_q,      tl_d;
    logic [2:0]  tcon_q,    tcon_d;
    logic [7:0]  led_q,     led_d;
    logic [15:0] digits_q,  digits_d;
    logic [31:0] systick_q, systick_d;
    logic [19:0] presc_q,   presc_d;
    logic [1:0]  idx_q,     idx_d;

    logic [2:0]  word;
    logic        wr_en;
    logic        overflow;
    logic        set_irq;
    logic [3:0]  nibble;
    logic [6:0]  seg_gfedcba;
    logic        unused_addr_lsbs;

    assign unused_addr_lsbs = ^addr[1:0];

    assign hit   = (addr[31:5] == 27'h200_0000);
    assign word  = addr[4:2];
    assign wr_en = MemWrite & hit;

    // Timer overflow is evaluated from the current state only; a same-cycle
    // TCON write cannot suppress an interrupt already due this cycle.
    assign overflow = tcon_q[0] && (tl_q == 32'hFFFF_FFFF);
    assign set_irq  = overflow && tcon_q[1];

    // Active-low hex decode, bit order g..a.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        case (h)
            4'h0: hex_to_seg = 7'h40;
            4'h1: hex_to_seg = 7'h79;
            4'h2: hex_to_seg = 7'h24;
            4'h3: hex_to_seg = 7'h30;
            4'h4: hex_to_seg = 7'h19;
            4'h5: hex_to_seg = 7'h12;
            4'h6: hex_to_seg = 7'h02;
            4'h7: hex_to_seg = 7'h78;
            4'h8: hex_to_seg = 7'h00;
            4'h9: hex_to_seg = 7'h10;
            4'hA: hex_to_seg = 7'h08;
            4'hB: hex_to_seg = 7'h03;
            4'hC: hex_to_seg = 7'h46;
            4'hD: hex_to_seg = 7'h21;
            4'hE: hex_to_seg = 7'h06;
            default: hex_to_seg = 7'h0E;
        endcase
    endfunction

    always_comb begin
        th_d      = th_q;
        tl_d      = tl_q;
        tcon_d    = tcon_q;
        led_d     = led_q;
        digits_d  = digits_q;
        systick_d = systick_q + 32'd1;
        presc_d   = presc_q + 20'd1;
        idx_d     = idx_q;

        if (tcon_q[0]) begin
            tl_d = overflow ? th_q : tl_q + 32'd1;
        end
        tcon_d[2] = tcon_q[2] | set_irq;

        if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            idx_d   = idx_q + 2'd1;
        end

        // Software writes override the autonomous updates above, except that
        // an interrupt raised this cycle survives a write clearing bit 2.
        if (wr_en) begin
            case (word)
                REG_TH:      th_d      = wdata;
                REG_TL:      tl_d      = wdata;
                REG_TCON:    tcon_d    = {wdata[2] | set_irq, wdata[1:0]};
                REG_LED:     led_d     = wdata[7:0];
                REG_DIGITS:  digits_d  = wdata[15:0];
                REG_SYSTICK: systick_d = wdata;
                default:     ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            th_q      <= '0;
            tl_q      <= '0;
            tcon_q    <= '0;
            led_q     <= '0;
            digits_q  <= '0;
            systick_q <= '0;
            presc_q   <= '0;
            idx_q     <= '0;
        end else begin
            th_q      <= th_d;
            tl_q      <= tl_d;
            tcon_q    <= tcon_d;
            led_q     <= led_d;
            digits_q  <= digits_d;
            systick_q <= systick_d;
            presc_q   <= presc_d;
            idx_q     <= idx_d;
        end
    end

    always_comb begin
        rdata = 32'h0;
        if (MemRead && hit) begin
            case (word)
                REG_TH:      rdata = th_q;
                REG_TL:      rdata = tl_q;
                REG_TCON:    rdata = {29'h0, tcon_q};
                REG_LED:     rdata = {24'h0, led_q};
                REG_DIGITS:  rdata = {16'h0, digits_q};
                REG_SYSTICK: rdata = systick_q;
                default:     rdata = 32'h0;
            endcase
        end
    end

    // Pin outputs depend only on flops, never on the bus inputs.
    assign nibble      = digits_q[idx_q*4 +: 4];
    assign seg_gfedcba = hex_to_seg(nibble);
    assign irq         = tcon_q[2];
    assign leds        = led_q;
    assign an          = ~(4'b0001 << idx_q);
    assign seg         = {1'b1, seg_gfedcba};

endmodule
